// File: rtl/adc_pack_pkg.sv
// Shared helpers for the generic ADC channel packer: sizing and enable-mask arithmetic.
package adc_pack_pkg;

   localparam int unsigned MAX_CHANNELS = 16;
   localparam int unsigned DEF_NUM_OF_CHANNELS = 4;
   localparam int unsigned DEF_CHANNEL_DATA_WIDTH = 16;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned popcount(input logic [MAX_CHANNELS-1:0] v);
      int unsigned c;
      c = 0;
      for (int unsigned i = 0; i < MAX_CHANNELS; i++) c += {31'd0, v[i]};
      return c;
   endfunction

   function automatic logic is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/adc_pack_compact.sv
// Compacts the enabled channels into the low lanes, preserving ascending channel order.
module adc_pack_compact
   import adc_pack_pkg::*;
#(
   parameter int unsigned NUM_OF_CHANNELS    = DEF_NUM_OF_CHANNELS,
   parameter int unsigned CHANNEL_DATA_WIDTH = DEF_CHANNEL_DATA_WIDTH
) (
   input  logic [NUM_OF_CHANNELS-1:0]                    enable_i,
   input  logic [NUM_OF_CHANNELS*CHANNEL_DATA_WIDTH-1:0] data_i,
   output logic [NUM_OF_CHANNELS*CHANNEL_DATA_WIDTH-1:0] lanes_o
);

   localparam int unsigned W = CHANNEL_DATA_WIDTH;

   always_comb begin
      int unsigned lane;
      lane = 0;
      lanes_o = '0;
      // lane is the running prefix popcount of enable_i[k-1:0]
      for (int unsigned k = 0; k < NUM_OF_CHANNELS; k++) begin
         if (enable_i[k]) begin
            lanes_o[lane*W +: W] = data_i[k*W +: W];
            lane++;
         end
      end
   end

endmodule

// File: rtl/adc_generic_pack.sv
// Generic ADC channel packer: accumulates compacted samples into full words with a
// valid/ready output, sync marking after reset/enable change, and overflow reporting.
module adc_generic_pack
   import adc_pack_pkg::*;
#(
   parameter int unsigned NUM_OF_CHANNELS    = DEF_NUM_OF_CHANNELS,
   parameter int unsigned CHANNEL_DATA_WIDTH = DEF_CHANNEL_DATA_WIDTH
) (
   input  logic                                          adc_clk,
   input  logic                                          adc_rst,
   input  logic [NUM_OF_CHANNELS-1:0]                    adc_enable,
   input  logic                                          adc_valid,
   input  logic [NUM_OF_CHANNELS*CHANNEL_DATA_WIDTH-1:0] adc_data,
   output logic                                          packed_valid,
   input  logic                                          packed_ready,
   output logic [NUM_OF_CHANNELS*CHANNEL_DATA_WIDTH-1:0] packed_data,
   output logic                                          packed_sync,
   output logic                                          adc_dovf,
   output logic                                          cfg_err
);

   localparam int unsigned N      = NUM_OF_CHANNELS;
   localparam int unsigned W      = CHANNEL_DATA_WIDTH;
   localparam int unsigned FILL_W = clog2(N) + 1;
   localparam int unsigned DATA_W = N * W;

   logic [FILL_W-1:0]       fill_q, fill_d;
   logic [DATA_W-1:0]       acc_q, acc_d;
   logic [N-1:0]            en_q;
   logic                    sync_pending_q, sync_pending_d;
   logic                    valid_q, valid_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    sync_q, sync_d;
   logic                    dovf_q, dovf_d;
   logic                    cfg_err_q, cfg_err_d;
   logic [DATA_W-1:0]       lanes;
   logic [MAX_CHANNELS-1:0] en_ext;
   int unsigned             num_en;
   int unsigned             fill_u;
   logic                    cfg_ok;
   logic                    en_change;

   adc_pack_compact #(
      .NUM_OF_CHANNELS    (N),
      .CHANNEL_DATA_WIDTH (W)
   ) u_compact (
      .enable_i (adc_enable),
      .data_i   (adc_data),
      .lanes_o  (lanes)
   );

   always_comb begin
      en_ext = '0;
      en_ext[N-1:0] = adc_enable;
      num_en = popcount(en_ext);
      cfg_ok = is_pow2(num_en) && (num_en <= N);
      en_change = (adc_enable != en_q);
      fill_u = 32'(fill_q);

      fill_d         = fill_q;
      acc_d          = acc_q;
      sync_pending_d = sync_pending_q;
      valid_d        = valid_q && !packed_ready;
      data_d         = data_q;
      sync_d         = sync_q;
      dovf_d         = 1'b0;
      cfg_err_d      = (num_en != 0) && !cfg_ok;

      if (en_change) begin
         fill_d         = '0;
         sync_pending_d = 1'b1;
      end else if (adc_valid && cfg_ok) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (i < num_en && (fill_u + i) < N) acc_d[(fill_u + i)*W +: W] = lanes[i*W +: W];
         end
         if (fill_u + num_en >= N) begin
            fill_d = '0;
            // Loading is allowed when the output slot is free or draining this cycle
            if (!valid_q || packed_ready) begin
               valid_d        = 1'b1;
               data_d         = acc_d;
               sync_d         = sync_pending_q;
               sync_pending_d = 1'b0;
            end else begin
               dovf_d = 1'b1;
            end
         end else begin
            fill_d = FILL_W'(fill_u + num_en);
         end
      end
   end

   always_ff @(posedge adc_clk or posedge adc_rst) begin
      if (adc_rst) begin
         fill_q         <= '0;
         acc_q          <= '0;
         en_q           <= '0;
         sync_pending_q <= 1'b1;
         valid_q        <= 1'b0;
         data_q         <= '0;
         sync_q         <= 1'b0;
         dovf_q         <= 1'b0;
         cfg_err_q      <= 1'b0;
      end else begin
         fill_q         <= fill_d;
         acc_q          <= acc_d;
         en_q           <= adc_enable;
         sync_pending_q <= sync_pending_d;
         valid_q        <= valid_d;
         data_q         <= data_d;
         sync_q         <= sync_d;
         dovf_q         <= dovf_d;
         cfg_err_q      <= cfg_err_d;
      end
   end

   assign packed_valid = valid_q;
   assign packed_data  = data_q;
   assign packed_sync  = sync_q;
   assign adc_dovf     = dovf_q;
   assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_adc_generic_pack.sv
// Self-checking bench for adc_generic_pack (4 channels x 16 bits).
module tb_adc_generic_pack;

   logic        clk;
   logic        rst;
   logic [3:0]  enable;
   logic        valid;
   logic [63:0] data;
   logic        pvalid;
   logic        pready;
   logic [63:0] pdata;
   logic        psync;
   logic        dovf;
   logic        cerr;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] data;
      logic        sync;
   } exp_t;
   exp_t sb[$];

   typedef struct packed {
      logic [3:0]       en;
      logic [2:0]       nv;
      logic [3:0][63:0] s;
      logic [63:0]      exp;
      logic             sync;
   } vec_t;
   vec_t vecs[6];

   adc_generic_pack #(
      .NUM_OF_CHANNELS    (4),
      .CHANNEL_DATA_WIDTH (16)
   ) dut (
      .adc_clk      (clk),
      .adc_rst      (rst),
      .adc_enable   (enable),
      .adc_valid    (valid),
      .adc_data     (data),
      .packed_valid (pvalid),
      .packed_ready (pready),
      .packed_data  (pdata),
      .packed_sync  (psync),
      .adc_dovf     (dovf),
      .cfg_err      (cerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d, input logic s);
      exp_t e;
      e.data = d;
      e.sync = s;
      sb.push_back(e);
   endtask

   task automatic set_vec(input int idx, input logic [3:0] en, input logic [2:0] nv,
                          input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] s3, input logic [63:0] exp, input logic sync);
      vecs[idx].en   = en;
      vecs[idx].nv   = nv;
      vecs[idx].s[0] = s0;
      vecs[idx].s[1] = s1;
      vecs[idx].s[2] = s2;
      vecs[idx].s[3] = s3;
      vecs[idx].exp  = exp;
      vecs[idx].sync = sync;
   endtask

   // Scoreboard: every accepted word must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && pvalid && pready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got word %h expected no word", pdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_data", pdata, e.data);
            chk("sb_sync", {63'd0, psync}, {63'd0, e.sync});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      enable = 4'b0000;
      valid = 1'b0;
      data = '0;
      pready = 1'b1;

      set_vec(0, 4'b1111, 3'd1, 64'h0004_0003_0002_0001, 64'h0, 64'h0, 64'h0,
              64'h0004_0003_0002_0001, 1'b1);
      set_vec(1, 4'b1111, 3'd1, 64'h0004_0003_0002_0001, 64'h0, 64'h0, 64'h0,
              64'h0004_0003_0002_0001, 1'b0);
      set_vec(2, 4'b0101, 3'd2, 64'h0000_00A2_0000_00A0, 64'h0000_00B2_0000_00B0, 64'h0, 64'h0,
              64'h00B2_00B0_00A2_00A0, 1'b1);
      set_vec(3, 4'b1000, 3'd4, 64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000,
              64'h0003_0000_0000_0000, 64'h0004_0000_0000_0000, 64'h0004_0003_0002_0001, 1'b1);
      set_vec(4, 4'b0011, 3'd2, 64'h0000_0000_0022_0011, 64'h0000_0000_0044_0033, 64'h0, 64'h0,
              64'h0044_0033_0022_0011, 1'b1);
      set_vec(5, 4'b0110, 3'd2, 64'h0000_000B_000A_0000, 64'h0000_000D_000C_0000, 64'h0, 64'h0,
              64'h000D_000C_000B_000A, 1'b1);

      tick();
      tick();
      chk("rst_valid", {63'd0, pvalid}, 64'd0);
      chk("rst_data", pdata, 64'd0);
      chk("rst_sync", {63'd0, psync}, 64'd0);
      chk("rst_dovf", {63'd0, dovf}, 64'd0);
      chk("rst_cfg_err", {63'd0, cerr}, 64'd0);
      rst = 1'b0;
      tick();

      // Table of single-word packing cases
      for (int r = 0; r < 6; r++) begin
         enable = vecs[r].en;
         valid = 1'b0;
         tick();
         for (int j = 0; j < int'(vecs[r].nv); j++) begin
            data = vecs[r].s[j];
            valid = 1'b1;
            if (j == int'(vecs[r].nv) - 1) push(vecs[r].exp, vecs[r].sync);
            tick();
            if (j < int'(vecs[r].nv) - 1) chk("vec_partial_valid", {63'd0, pvalid}, 64'd0);
         end
         chk("vec_valid", {63'd0, pvalid}, 64'd1);
         chk("vec_data", pdata, vecs[r].exp);
         chk("vec_sync", {63'd0, psync}, {63'd0, vecs[r].sync});
         valid = 1'b0;
      end

      // Back-pressure: first word held, second dropped with a one-cycle dovf
      enable = 4'b1111;
      tick();
      pready = 1'b0;
      data = 64'h1114_1113_1112_1111;
      valid = 1'b1;
      push(64'h1114_1113_1112_1111, 1'b1);
      tick();
      chk("bp_valid", {63'd0, pvalid}, 64'd1);
      chk("bp_dovf_idle", {63'd0, dovf}, 64'd0);
      data = 64'h2224_2223_2222_2221;
      tick();
      chk("bp_dovf_pulse", {63'd0, dovf}, 64'd1);
      chk("bp_held_data", pdata, 64'h1114_1113_1112_1111);
      valid = 1'b0;
      tick();
      chk("bp_dovf_end", {63'd0, dovf}, 64'd0);
      chk("bp_still_held", pdata, 64'h1114_1113_1112_1111);
      pready = 1'b1;
      tick();
      chk("bp_drained", {63'd0, pvalid}, 64'd0);

      // Full-rate streaming with ready high: no bubbles, no overflow
      for (int k = 0; k < 3; k++) begin
         logic [63:0] w;
         w = {16'(k + 'h34), 16'(k + 'h33), 16'(k + 'h32), 16'(k + 'h31)};
         data = w;
         valid = 1'b1;
         push(w, 1'b0);
         tick();
         chk("b2b_valid", {63'd0, pvalid}, 64'd1);
         chk("b2b_data", pdata, w);
         chk("b2b_dovf", {63'd0, dovf}, 64'd0);
      end
      valid = 1'b0;
      tick();

      // Enable change together with valid drops the sample and the partial word
      enable = 4'b0001;
      tick();
      data = 64'h51;
      valid = 1'b1;
      tick();
      data = 64'h52;
      tick();
      chk("ch_partial", {63'd0, pvalid}, 64'd0);
      enable = 4'b0011;
      data = 64'h0000_0000_0062_0061;
      tick();
      chk("ch_dropped", {63'd0, pvalid}, 64'd0);
      data = 64'h0000_0000_0072_0071;
      tick();
      chk("ch_half", {63'd0, pvalid}, 64'd0);
      data = 64'h0000_0000_0074_0073;
      push(64'h0074_0073_0072_0071, 1'b1);
      tick();
      chk("ch_valid", {63'd0, pvalid}, 64'd1);
      chk("ch_data", pdata, 64'h0074_0073_0072_0071);
      chk("ch_sync", {63'd0, psync}, 64'd1);
      valid = 1'b0;

      // Illegal enable mask: cfg_err set, valid ignored
      enable = 4'b0111;
      tick();
      chk("cfg_err_set", {63'd0, cerr}, 64'd1);
      valid = 1'b1;
      data = 64'h0777_0666_0555_0444;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("cfg_no_output", {63'd0, pvalid}, 64'd0);
      end
      valid = 1'b0;
      enable = 4'b1111;
      tick();
      chk("cfg_err_clear", {63'd0, cerr}, 64'd0);

      // Asynchronous reset with a held word and cfg_err asserted
      pready = 1'b0;
      data = 64'h0C04_0C03_0C02_0C01;
      valid = 1'b1;
      tick();
      chk("pre_rst_valid", {63'd0, pvalid}, 64'd1);
      valid = 1'b0;
      enable = 4'b0111;
      tick();
      chk("pre_rst_cfg_err", {63'd0, cerr}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {63'd0, pvalid}, 64'd0);
      chk("arst_data", pdata, 64'd0);
      chk("arst_sync", {63'd0, psync}, 64'd0);
      chk("arst_dovf", {63'd0, dovf}, 64'd0);
      chk("arst_cfg_err", {63'd0, cerr}, 64'd0);
      tick();
      rst = 1'b0;
      pready = 1'b1;
      enable = 4'b1111;
      tick();
      data = 64'h0D04_0D03_0D02_0D01;
      valid = 1'b1;
      push(64'h0D04_0D03_0D02_0D01, 1'b1);
      tick();
      chk("post_rst_valid", {63'd0, pvalid}, 64'd1);
      chk("post_rst_sync", {63'd0, psync}, 64'd1);
      valid = 1'b0;
      tick();
      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
